c_decode_skid: RTL and testbench
================================

Name: c_decode_skid

Overview:
- Registered binary-to-one-hot port decoder with valid/ready flow control. It is the inverse of c_encode: it turns a port index back into a one-hot port select, honouring the same offset convention.
- Sits on the path from a routing/allocation stage that produces binary port indices to crossbar or VC select logic that needs one-hot controls.
- A 2-entry skid buffer gives full throughput with a registered in_ready.
- Out-of-range indices are flagged per item and recorded in a sticky error.

Parameters:
- num_ports, 8, number of one-hot output bits; legal range 2 and up, need not be a power of 2.
- offset, 0, rotation matching c_encode; legal range 0..num_ports-1.
- width (localparam), clogb(num_ports), width of the binary index.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input item present.
- in_ready  output  1  block can accept; registered.
- in_data  input  width  binary port index.
- out_valid  output  1  output item present.
- out_ready  input  1  downstream accepts.
- out_data  output  num_ports  one-hot decoded select, bit 0 = MSB index [0].
- out_invalid  output  1  current output item was out of range.
- error  output  1  sticky; any out-of-range index accepted since reset.

Behaviour:
- Decode:
  - Decoded position p = (in_data + num_ports - offset) mod num_ports, computed at width+1 bits.
  - out_data[p] = 1, all other bits 0.
  - This is the exact inverse of c_encode: c_encode(c_decode(v)) == v for all v < num_ports.
- Out of range: if in_data >= num_ports (only possible when num_ports is not a power of 2), the stored one-hot is all zeros and the stored invalid bit is 1.
- Decode is done before storage; registers hold the one-hot vector plus the invalid bit.
- Storage: main register (drives outputs) and skid register.
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: main valid, skid valid.
- Transfer conditions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- State transitions:
  - EMPTY + accept -> ONE; the item is loaded into main.
  - ONE + accept & !drain -> FULL; the item is loaded into skid.
  - ONE + accept & drain -> ONE; main is reloaded with the new item.
  - ONE + !accept & drain -> EMPTY.
  - FULL + drain -> ONE; skid moves to main.
  - Accept is impossible in FULL because in_ready = 0.
- Flow-control signals:
  - in_ready = !skid_valid, registered. It deasserts the cycle after entering FULL and reasserts the cycle after leaving it.
  - out_valid = main_valid.
- Latency: 1 cycle; an item accepted in cycle n is on out_data in cycle n+1 when the buffer was EMPTY or draining.
- Throughput: 1 item/cycle with out_ready held high.
- Ordering: strict FIFO.
- When out_valid = 0: out_data = 0 and out_invalid = 0, forced; they never hold stale data.
- error:
  - Set in the cycle after an out-of-range item is accepted, coincident with its storage.
  - Remains 1 until reset; it is not cleared by draining.
- Reset:
  - Asynchronous on reset rise.
  - Outputs: out_valid = 0, out_data = 0, out_invalid = 0, error = 0, in_ready = 1.
  - Internal state returns to EMPTY.
  - Reset mid-operation discards buffered items without emitting them.
  - in_ready is 1 in the first cycle after reset deasserts.
- Holding rules: in_data is ignored when in_valid = 0. A held output may not change while out_valid & !out_ready.

Decomposition:
- clogb and related width helpers come from the shared c_functions include. No new shared constants are needed; state encodings are local to the module.
- One combinational sub-module: c_decode (num_ports, offset). It is the mirror of c_encode and is instantiated once on the input path.
- The skid/state logic stays in c_decode_skid.

Test Plan:
- Sweep, num_ports=8, offset=0, out_ready=1: in_data 0..7 back-to-back -> out_data 10000000 .. 00000001 one cycle later, one per cycle, out_invalid=0, error=0.
- Offset rotation, num_ports=8, offset=3:
  - in_data=3 -> out_data=10000000.
  - in_data=2 -> out_data=00000001.
  - Feeding each output into a c_encode instance with the same offset returns the original index for all 8 values.
- Backpressure:
  - Send 5,6,7 with out_ready=0 -> in_ready drops to 0 after two items accepted; 7 is held off.
  - Raise out_ready -> outputs in order 00000100, 00000010, then 00000001; no loss or duplication.
  - With out_ready toggling randomly, the output sequence matches the input order.
- Out of range, num_ports=5, offset=0:
  - in_data=6 -> out_data=00000, out_invalid=1, error=1.
  - Next in_data=2 -> out_data=00100, out_invalid=0, error stays 1.
- Reset mid-operation: buffer in FULL, assert reset asynchronously between clock edges -> out_valid=0, out_data=0 and error=0 immediately; in_ready=1 after release; the previously buffered items never appear.

Source files
------------

// File: rtl/c_decode_skid_pkg.sv
// Shared helpers and state encoding for the c_decode_skid block.
package c_decode_skid_pkg;

  // Ceiling log2, minimum 1 bit; width of a binary index for 'value' ports.
  function automatic int clogb(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/c_decode_skid_if.sv
// Valid/ready bus carrying a binary port index in and a one-hot select out.
interface c_decode_skid_if import c_decode_skid_pkg::*; #(
  parameter int num_ports = 8
);
  localparam int width = clogb(num_ports);

  logic                   in_valid;
  logic                   in_ready;
  logic [width-1:0]       in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [0:num_ports-1]   out_data;
  logic                   out_invalid;
  logic                   error;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_invalid, error
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_invalid, error
  );
endinterface

// File: rtl/c_decode_skid_decode.sv
// Combinational binary-to-one-hot decoder, the inverse of c_encode with the same offset.
module c_decode import c_decode_skid_pkg::*; #(
  parameter int num_ports = 8,
  parameter int offset    = 0,
  localparam int width    = clogb(num_ports)
) (
  input  logic [width-1:0]     data_in,
  output logic [0:num_ports-1] data_out,
  output logic                 invalid
);

  logic [width:0] pos;

  always_comb begin
    data_out = '0;
    invalid  = 1'b0;
    // One extra bit keeps data_in + (num_ports - offset) from wrapping before the modulo.
    pos = (width+1)'(data_in) + (width+1)'(num_ports - offset);
    if (pos >= (width+1)'(num_ports)) pos = pos - (width+1)'(num_ports);
    if ((width+1)'(data_in) >= (width+1)'(num_ports)) begin
      invalid = 1'b1;
    end else begin
      for (int unsigned i = 0; i < num_ports; i++) begin
        if (pos == (width+1)'(i)) data_out[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/c_decode_skid.sv
// Registered one-hot port decoder behind a 2-entry skid buffer with sticky range error.
module c_decode_skid import c_decode_skid_pkg::*; #(
  parameter int num_ports = 8,
  parameter int offset    = 0
) (
  input logic            clk,
  input logic            reset,
  c_decode_skid_if.slave bus
);

  skid_state_t          state_q, state_d;
  logic [0:num_ports-1] dec_data, main_data, skid_data;
  logic                 dec_inv, main_inv, skid_inv;
  logic                 in_ready_q, error_q;
  logic                 main_valid, accept, drain;
  logic                 load_main_in, load_main_skid, load_skid;

  c_decode #(
    .num_ports (num_ports),
    .offset    (offset)
  ) u_decode (
    .data_in  (bus.in_data),
    .data_out (dec_data),
    .invalid  (dec_inv)
  );

  assign main_valid = (state_q != ST_EMPTY);
  assign accept     = bus.in_valid & in_ready_q;
  assign drain      = main_valid & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d      = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !drain) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a drain can occur.
        if (drain) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      error_q    <= 1'b0;
      main_data  <= '0;
      main_inv   <= 1'b0;
      skid_data  <= '0;
      skid_inv   <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      if (accept && dec_inv) error_q <= 1'b1;
      if (load_main_in) begin
        main_data <= dec_data;
        main_inv  <= dec_inv;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_inv  <= skid_inv;
      end
      if (load_skid) begin
        skid_data <= dec_data;
        skid_inv  <= dec_inv;
      end
    end
  end

  // Outputs are forced to zero when empty so no stale item is ever visible.
  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = main_valid;
  assign bus.out_data    = main_valid ? main_data : '0;
  assign bus.out_invalid = main_valid & main_inv;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_c_decode_skid.sv
// Bench for c_decode_skid: vector table, backpressure/reset sequences and a randomized scoreboard run.
module tb_c_decode_skid;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  c_decode_skid_if #(.num_ports(8)) ifa ();
  c_decode_skid_if #(.num_ports(8)) ifb ();
  c_decode_skid_if #(.num_ports(5)) ifc ();

  c_decode_skid #(.num_ports(8), .offset(0)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  c_decode_skid #(.num_ports(8), .offset(3)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
  c_decode_skid #(.num_ports(5), .offset(0)) dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         sel;
    int         din;
    logic [7:0] exp;
    logic       inv;
    logic       err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        inv;
  } item_t;

  vec_t  tbl[22];
  item_t q[$];

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference decode written from the rule: position p is the inverse rotation of v.
  function automatic item_t model(input int n, input int off, input int v);
    item_t it;
    int p;
    it.data = '0;
    it.inv  = 1'b0;
    if (v >= n) begin
      it.inv = 1'b1;
    end else begin
      p = ((v - off) % n + n) % n;
      it.data = 32'(1) << (n - 1 - p);
    end
    return it;
  endfunction

  // Reference encode: recovers the index from a one-hot value (MSB is position 0).
  function automatic int encode(input int n, input int off, input logic [31:0] oh);
    int p;
    p = -1;
    for (int i = 0; i < n; i++) if (oh[n-1-i]) p = i;
    if (p < 0) return -1;
    return (p + off) % n;
  endfunction

  task automatic drive(input int sel, input logic v, input int d);
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
    ifc.in_valid = 1'b0;
    case (sel)
      0: begin ifa.in_valid = v; ifa.in_data = 3'(d); end
      1: begin ifb.in_valid = v; ifb.in_data = 3'(d); end
      default: begin ifc.in_valid = v; ifc.in_data = 3'(d); end
    endcase
  endtask

  task automatic get_out(input int sel, output logic ov, output logic [31:0] od,
                         output logic oi, output logic er, output logic ir);
    case (sel)
      0: begin ov = ifa.out_valid; od = 32'(ifa.out_data); oi = ifa.out_invalid; er = ifa.error; ir = ifa.in_ready; end
      1: begin ov = ifb.out_valid; od = 32'(ifb.out_data); oi = ifb.out_invalid; er = ifb.error; ir = ifb.in_ready; end
      default: begin ov = ifc.out_valid; od = 32'(ifc.out_data); oi = ifc.out_invalid; er = ifc.error; ir = ifc.in_ready; end
    endcase
  endtask

  task automatic chk_a(input string name, input logic ev, input logic [31:0] ed, input logic eir);
    cmp({name, "_valid"}, 32'(ifa.out_valid), 32'(ev));
    cmp({name, "_data"}, 32'(ifa.out_data), ed);
    cmp({name, "_ready"}, 32'(ifa.in_ready), 32'(eir));
  endtask

  // One randomized cycle on dut_a; the queue length is the buffer occupancy.
  task automatic rnd_cycle(input logic allow_in);
    item_t exp_it;
    logic  acc, drn;
    ifa.in_valid  = allow_in ? 1'($urandom_range(0, 1)) : 1'b0;
    ifa.in_data   = 3'($urandom_range(0, 7));
    ifa.out_ready = allow_in ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    cmp("rnd_in_ready", 32'(ifa.in_ready), 32'(q.size() < 2));
    cmp("rnd_out_valid", 32'(ifa.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      cmp("rnd_out_data", 32'(ifa.out_data), q[0].data);
      cmp("rnd_out_invalid", 32'(ifa.out_invalid), 32'(q[0].inv));
    end else begin
      cmp("rnd_idle_data", 32'(ifa.out_data), 32'd0);
    end
    acc = ifa.in_valid && (q.size() < 2);
    drn = ifa.out_ready && (q.size() > 0);
    exp_it = model(8, 0, int'(ifa.in_data));
    if (drn) void'(q.pop_front());
    if (acc) q.push_back(exp_it);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        ov, oi, er, ir;
    logic [31:0] od;
    total = 0;
    bad   = 0;

    tbl[0]  = '{0, 0, 8'b10000000, 1'b0, 1'b0};
    tbl[1]  = '{0, 1, 8'b01000000, 1'b0, 1'b0};
    tbl[2]  = '{0, 2, 8'b00100000, 1'b0, 1'b0};
    tbl[3]  = '{0, 3, 8'b00010000, 1'b0, 1'b0};
    tbl[4]  = '{0, 4, 8'b00001000, 1'b0, 1'b0};
    tbl[5]  = '{0, 5, 8'b00000100, 1'b0, 1'b0};
    tbl[6]  = '{0, 6, 8'b00000010, 1'b0, 1'b0};
    tbl[7]  = '{0, 7, 8'b00000001, 1'b0, 1'b0};
    tbl[8]  = '{1, 3, 8'b10000000, 1'b0, 1'b0};
    tbl[9]  = '{1, 2, 8'b00000001, 1'b0, 1'b0};
    tbl[10] = '{1, 0, 8'b00000100, 1'b0, 1'b0};
    tbl[11] = '{1, 1, 8'b00000010, 1'b0, 1'b0};
    tbl[12] = '{1, 4, 8'b01000000, 1'b0, 1'b0};
    tbl[13] = '{1, 5, 8'b00100000, 1'b0, 1'b0};
    tbl[14] = '{1, 6, 8'b00010000, 1'b0, 1'b0};
    tbl[15] = '{1, 7, 8'b00001000, 1'b0, 1'b0};
    tbl[16] = '{2, 6, 8'b00000000, 1'b1, 1'b1};
    tbl[17] = '{2, 2, 8'b00000100, 1'b0, 1'b1};
    tbl[18] = '{2, 4, 8'b00000001, 1'b0, 1'b1};
    tbl[19] = '{2, 0, 8'b00010000, 1'b0, 1'b1};
    tbl[20] = '{2, 7, 8'b00000000, 1'b1, 1'b1};
    tbl[21] = '{2, 5, 8'b00000000, 1'b1, 1'b1};

    reset = 1'b1;
    drive(0, 1'b0, 0);
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    ifc.out_ready = 1'b1;
    #11;
    cmp("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    cmp("rst_out_data", 32'(ifa.out_data), 32'd0);
    cmp("rst_in_ready", 32'(ifa.in_ready), 32'd1);
    cmp("rst_error", 32'(ifc.error), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cmp("post_rst_in_ready", 32'(ifa.in_ready), 32'd1);

    // Table: back-to-back items, each visible one cycle after acceptance.
    foreach (tbl[i]) begin
      drive(tbl[i].sel, 1'b1, tbl[i].din);
      @(posedge clk);
      #1;
      get_out(tbl[i].sel, ov, od, oi, er, ir);
      cmp($sformatf("tbl%0d_valid", i), 32'(ov), 32'd1);
      cmp($sformatf("tbl%0d_data", i), od, 32'(tbl[i].exp));
      cmp($sformatf("tbl%0d_invalid", i), 32'(oi), 32'(tbl[i].inv));
      cmp($sformatf("tbl%0d_error", i), 32'(er), 32'(tbl[i].err));
      cmp($sformatf("tbl%0d_in_ready", i), 32'(ir), 32'd1);
      if (tbl[i].sel == 1)
        cmp($sformatf("tbl%0d_roundtrip", i), 32'(encode(8, 3, od)), 32'(tbl[i].din));
    end
    drive(0, 1'b0, 0);
    @(posedge clk);
    #1;
    chk_a("drained", 1'b0, 32'd0, 1'b1);

    // Backpressure: fill both entries, the third item must be held off.
    ifa.out_ready = 1'b0;
    drive(0, 1'b1, 5);
    @(posedge clk);
    #1;
    chk_a("bp1", 1'b1, 32'b00000100, 1'b1);
    drive(0, 1'b1, 6);
    @(posedge clk);
    #1;
    chk_a("bp2", 1'b1, 32'b00000100, 1'b0);
    drive(0, 1'b1, 7);
    @(posedge clk);
    #1;
    chk_a("bp3_hold", 1'b1, 32'b00000100, 1'b0);
    ifa.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_a("bp4", 1'b1, 32'b00000010, 1'b1);
    @(posedge clk);
    #1;
    chk_a("bp5", 1'b1, 32'b00000001, 1'b1);
    drive(0, 1'b0, 0);
    @(posedge clk);
    #1;
    chk_a("bp6", 1'b0, 32'd0, 1'b1);

    repeat (400) rnd_cycle(1'b1);
    repeat (4) rnd_cycle(1'b0);

    // Reset mid-operation with dut_a full and dut_c holding a sticky error.
    ifa.out_ready = 1'b0;
    drive(0, 1'b1, 1);
    @(posedge clk);
    #1;
    drive(0, 1'b1, 2);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 0);
    chk_a("full_before_rst", 1'b1, 32'b01000000, 1'b0);
    cmp("err_before_rst", 32'(ifc.error), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk_a("async_rst", 1'b0, 32'd0, 1'b1);
    cmp("async_rst_error", 32'(ifc.error), 32'd0);
    cmp("async_rst_invalid", 32'(ifa.out_invalid), 32'd0);
    #10;
    reset = 1'b0;
    ifa.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_a("after_rst1", 1'b0, 32'd0, 1'b1);
    @(posedge clk);
    #1;
    chk_a("after_rst2", 1'b0, 32'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
